hazard_forward_scoreboard: RTL

- Parametrised hazard-detection and forwarding controller for the in-order pipelined processor.
- Replaces fixed EX/MEM/WB compare logic with a DEPTH-entry shift-register scoreboard of in-flight destination registers, and adds configurable load latency.
- Sits beside the ID stage. It decides stall, bubble insertion and per-operand forwarding source, and counts stall cycles for performance checks in simulation.

---
 rtl/hazard_forward_scoreboard_if.sv | 36 +++
 rtl/hazard_forward_scoreboard.sv | 117 +++++++++++
 2 files changed

// File: rtl/hazard_forward_scoreboard_if.sv
// ID-stage hazard/forwarding bus: instruction fields from ID in,
// stall / forwarding selects / stall counter out.
interface hazard_forward_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  localparam int RAW = $clog2(NREG);
  localparam int FW  = $clog2(DEPTH + 1);

  logic             id_valid;
  logic [RAW-1:0]   id_rs1;
  logic [RAW-1:0]   id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [RAW-1:0]   id_rd;
  logic             id_rd_we;
  logic             id_is_load;
  logic             flush;
  logic             stall;
  logic [FW-1:0]    fwd_sel_a;
  logic [FW-1:0]    fwd_sel_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, flush,
    input  stall, fwd_sel_a, fwd_sel_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, flush,
    output stall, fwd_sel_a, fwd_sel_b, stall_count
  );
endinterface

// File: rtl/hazard_forward_scoreboard.sv
// Hazard detection and forwarding controller: DEPTH-position shift-register
// scoreboard of in-flight destinations (position 1 = EX, DEPTH = WB).

// Per-source lookup: youngest matching in-flight writer decides forward/stall.
module hfs_src_match #(
  parameter int RAW   = 5,
  parameter int FW    = 2,
  parameter int DEPTH = 3
) (
  input  logic                       id_valid,
  input  logic [RAW-1:0]             src,
  input  logic                       used,
  input  logic [DEPTH:1]             sb_vld,
  input  logic [DEPTH:1]             sb_we,
  input  logic [DEPTH:1][RAW-1:0]    sb_rd,
  input  logic [DEPTH:1][FW-1:0]     sb_rdy,
  output logic                       hazard,
  output logic [FW-1:0]              sel
);
  logic          hit;
  logic [FW-1:0] pos;
  logic [FW-1:0] rdy;

  // Scan oldest to youngest so the smallest matching position is kept last.
  always_comb begin
    hit = 1'b0;
    pos = '0;
    rdy = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && used && (src != '0) && sb_vld[k] && sb_we[k] &&
          (sb_rd[k] == src)) begin
        hit = 1'b1;
        pos = FW'(k);
        rdy = sb_rdy[k];
      end
    end
    hazard = hit && (pos < rdy);
    sel    = (hit && (pos >= rdy)) ? pos : '0;
  end
endmodule

module hazard_forward_scoreboard #(
  parameter int NREG     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  hazard_forward_scoreboard_if.slave  bus
);
  localparam int RAW = $clog2(NREG);
  localparam int FW  = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] RDY_ALU = FW'(1);
  localparam logic [FW-1:0] RDY_LD  = FW'(1 + LOAD_LAT);

  logic [DEPTH:1]          sb_vld;
  logic [DEPTH:1]          sb_we;
  logic [DEPTH:1][RAW-1:0] sb_rd;
  logic [DEPTH:1][FW-1:0]  sb_rdy;

  logic [1:0][RAW-1:0] src;
  logic [1:0]          used;
  logic [1:0]          hz;
  logic [1:0][FW-1:0]  sel;
  logic                stall_i;
  logic                ins;
  logic [CNT_W-1:0]    cnt;

  assign src  = {bus.id_rs2, bus.id_rs1};
  assign used = {bus.id_rs2_used, bus.id_rs1_used};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hfs_src_match #(.RAW(RAW), .FW(FW), .DEPTH(DEPTH)) u_match (
      .id_valid (bus.id_valid),
      .src      (src[g]),
      .used     (used[g]),
      .sb_vld   (sb_vld),
      .sb_we    (sb_we),
      .sb_rd    (sb_rd),
      .sb_rdy   (sb_rdy),
      .hazard   (hz[g]),
      .sel      (sel[g])
    );
  end

  // Flush wins over stall; a stalled or squashed ID turns into a bubble.
  assign stall_i         = (|hz) & ~bus.flush;
  assign ins             = bus.id_valid & ~stall_i & ~bus.flush;
  assign bus.stall       = stall_i;
  assign bus.fwd_sel_a   = sel[0];
  assign bus.fwd_sel_b   = sel[1];
  assign bus.stall_count = cnt;

  // Advance every entry one position; position 1 takes ID or a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld <= '0;
      sb_we  <= '0;
      sb_rd  <= '0;
      sb_rdy <= '0;
    end else begin
      sb_vld <= {sb_vld[DEPTH-1:1], ins};
      sb_we  <= {sb_we[DEPTH-1:1], bus.id_rd_we};
      sb_rd  <= {sb_rd[DEPTH-1:1], bus.id_rd};
      sb_rdy <= {sb_rdy[DEPTH-1:1], (bus.id_is_load ? RDY_LD : RDY_ALU)};
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (stall_i && (cnt != '1))
      cnt <= cnt + 1'b1;
  end
endmodule
